// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM stage and its SRAM controller.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int MEM_BASE_DEF = 1024;
    localparam int SRAM_ADDR_W  = 18;

    // 32-bit word index inside the SRAM window; the two byte-offset bits are dropped.
    function automatic logic [SRAM_ADDR_W-2:0] word_index(input logic [31:0] byte_addr,
                                                           input logic [31:0] base);
        logic [31:0] off;
        off = byte_addr - base;
        return off[SRAM_ADDR_W:2];
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// 16-bit external SRAM pin bundle; master drives the pins, slave is the memory.
interface mem_stage_if;
    import arm_pkg::*;

    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [15:0]            sram_dq_out;
    logic [15:0]            sram_dq_in;
    logic                   sram_we_n;

    modport master (
        output sram_addr,
        output sram_dq_out,
        output sram_we_n,
        input  sram_dq_in
    );

    modport slave (
        input  sram_addr,
        input  sram_dq_out,
        input  sram_we_n,
        output sram_dq_in
    );

endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// SRAM access sequencer: splits one 32-bit load/store into two 16-bit halves,
// each held for WAIT cycles on the external pins.
module sram_ctrl
    import arm_pkg::*;
#(
    parameter int WAIT     = 2,
    parameter int MEM_BASE = MEM_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_result,
    input  logic [31:0] val_rm,
    output logic        ready,
    output logic        rd_vld,
    output logic [31:0] rd_data,
    mem_stage_if.master sram
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT - 1);

    mem_state_e             state, state_nxt;
    logic [3:0]             cnt, cnt_nxt;
    logic [SRAM_ADDR_W-2:0] addr_lat;
    logic [31:0]            data_lat;
    logic                   store_lat;
    logic [15:0]            lo_q, hi_q;
    logic                   req;
    logic                   last;

    assign req  = mem_r_en | mem_w_en;
    assign last = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            addr_lat  <= '0;
            data_lat  <= 32'd0;
            store_lat <= 1'b0;
            lo_q      <= 16'd0;
            hi_q      <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req) begin
                addr_lat  <= word_index(alu_result, 32'(MEM_BASE));
                data_lat  <= val_rm;
                store_lat <= mem_w_en;
            end
            // Read data is taken at the end of each half's wait window.
            if (state == LO && last && !store_lat) lo_q <= sram.sram_dq_in;
            if (state == HI && last && !store_lat) hi_q <= sram.sram_dq_in;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = !req;
                if (req) begin
                    state_nxt = LO;
                    cnt_nxt   = 4'd0;
                end
            end
            LO: begin
                if (last) begin
                    state_nxt = HI;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HI: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sram.sram_addr   = {addr_lat, (state == HI)};
        sram.sram_we_n   = 1'b1;
        sram.sram_dq_out = 16'd0;
        if (store_lat && state == LO) begin
            sram.sram_we_n   = 1'b0;
            sram.sram_dq_out = data_lat[15:0];
        end else if (store_lat && state == HI) begin
            sram.sram_we_n   = 1'b0;
            sram.sram_dq_out = data_lat[31:16];
        end
    end

    assign rd_vld  = (state == DONE) && !store_lat;
    assign rd_data = {hi_q, lo_q};

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: SRAM access through sram_ctrl plus the MEM/WB register,
// which inserts bubbles while an access is in flight.
module mem_stage
    import arm_pkg::*;
#(
    parameter int WAIT     = 2,
    parameter int MEM_BASE = MEM_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_result,
    input  logic [31:0] val_rm,
    input  logic [3:0]  dest_in,
    output logic        ready,
    output logic [31:0] Result_WB,
    output logic [3:0]  Dest_wb,
    output logic        writeBackEn,
    mem_stage_if.master sram
);

    logic        rd_vld;
    logic [31:0] rd_data;
    logic [31:0] result_p1;
    logic [3:0]  dest_p1;
    logic        vld_p1;

    sram_ctrl #(
        .WAIT     (WAIT),
        .MEM_BASE (MEM_BASE)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .alu_result (alu_result),
        .val_rm     (val_rm),
        .ready      (ready),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .sram       (sram)
    );

    // MEM/WB boundary: capture on ready, otherwise hold data and emit a bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_p1 <= 32'd0;
            dest_p1   <= 4'd0;
            vld_p1    <= 1'b0;
        end else if (ready) begin
            result_p1 <= rd_vld ? rd_data : alu_result;
            dest_p1   <= dest_in;
            vld_p1    <= wb_en_in;
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    assign Result_WB   = result_p1;
    assign Dest_wb     = dest_p1;
    assign writeBackEn = vld_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized checks of mem_stage against a word-level memory model.
module tb_mem_stage;
    localparam int WAIT     = 2;
    localparam int MEM_BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en, mem_w_en;
    logic [31:0] alu_result, val_rm;
    logic [3:0]  dest_in;
    logic        ready;
    logic [31:0] Result_WB;
    logic [3:0]  Dest_wb;
    logic        writeBackEn;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] mem     [0:1023];
    logic [15:0] ref_mem [0:1023];

    mem_stage_if sif ();

    mem_stage #(.WAIT(WAIT), .MEM_BASE(MEM_BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en_in    (wb_en_in),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .alu_result  (alu_result),
        .val_rm      (val_rm),
        .dest_in     (dest_in),
        .ready       (ready),
        .Result_WB   (Result_WB),
        .Dest_wb     (Dest_wb),
        .writeBackEn (writeBackEn),
        .sram        (sif)
    );

    always #5 clk = ~clk;

    // Asynchronous-read SRAM with a clocked write port.
    always_comb begin
        sif.sram_dq_in = (sif.sram_addr < 18'd1024) ? mem[sif.sram_addr[9:0]] : 16'h0;
    end

    always @(posedge clk) begin
        if (!sif.sram_we_n && sif.sram_addr < 18'd1024)
            mem[sif.sram_addr[9:0]] <= sif.sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // op: 0 = non-memory, 1 = load, 2 = store, 3 = load+store (acts as store)
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] dst, input logic wb);
        bit          is_mem, is_st, h;
        int          k, cyc;
        logic [31:0] exp_res;
        is_mem     = (op != 0);
        is_st      = (op >= 2);
        wb_en_in   = wb;
        mem_r_en   = (op == 1 || op == 3);
        mem_w_en   = is_st;
        alu_result = a;
        val_rm     = d;
        dest_in    = dst;
        k = is_mem ? int'((a - 32'(MEM_BASE)) >> 2) : 0;
        #1;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 20) begin
            if (cyc == 0) begin
                check("we_n_idle", 32'(sif.sram_we_n), 32'd1);
            end else begin
                h = (cyc > WAIT);
                check("we_n_busy", 32'(sif.sram_we_n), is_st ? 32'd0 : 32'd1);
                check("addr", 32'(sif.sram_addr), 32'(2 * k + int'(h)));
                check("dq_out", 32'(sif.sram_dq_out),
                      is_st ? (h ? 32'(d[31:16]) : 32'(d[15:0])) : 32'd0);
                check("bubble", 32'(writeBackEn), 32'd0);
            end
            cyc++;
            @(negedge clk);
            #1;
        end
        check("busy_len", 32'(cyc), is_mem ? 32'(2 * WAIT + 1) : 32'd0);
        exp_res = (op == 1) ? {ref_mem[2*k+1], ref_mem[2*k]} : a;
        if (is_st) begin
            ref_mem[2*k]   = d[15:0];
            ref_mem[2*k+1] = d[31:16];
        end
        @(negedge clk);
        check("result_wb", Result_WB, exp_res);
        check("dest_wb", 32'(Dest_wb), 32'(dst));
        check("wb_en", 32'(writeBackEn), 32'(wb));
        if (is_st) begin
            check("mem_lo", 32'(mem[2*k]), 32'(ref_mem[2*k]));
            check("mem_hi", 32'(mem[2*k+1]), 32'(ref_mem[2*k+1]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b0; wb_en_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        alu_result = 32'd0; val_rm = 32'd0; dest_in = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_wbe", 32'(writeBackEn), 32'd0);
        check("rst_result", Result_WB, 32'd0);
        check("rst_dest", 32'(Dest_wb), 32'd0);
        check("rst_we_n", 32'(sif.sram_we_n), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        rst = 1'b1;

        run_op(0, 32'h55, 32'h0, 4'd3, 1'b1);
        run_op(2, 32'd1028, 32'hDEADBEEF, 4'd0, 1'b0);
        run_op(1, 32'd1028, 32'h0, 4'd5, 1'b1);
        run_op(3, 32'd1100, 32'hCAFE1234, 4'd7, 1'b1);

        // Reset in the first HI cycle of a store.
        wb_en_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b1;
        alu_result = 32'd1088; val_rm = 32'hA5A55A5A; dest_in = 4'd9;
        repeat (WAIT + 1) @(negedge clk);
        #1;
        check("abort_pre_we_n", 32'(sif.sram_we_n), 32'd0);
        check("abort_pre_addr", 32'(sif.sram_addr), 32'd33);
        rst = 1'b0; mem_w_en = 1'b0;
        @(negedge clk);
        #1;
        check("abort_we_n", 32'(sif.sram_we_n), 32'd1);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_wbe", 32'(writeBackEn), 32'd0);
        check("abort_result", Result_WB, 32'd0);
        rst = 1'b1;
        run_op(2, 32'd1088, 32'h13579BDF, 4'd0, 1'b0);
        run_op(1, 32'd1090, 32'h0, 4'd2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 3));
            if (op == 0) a = $urandom;
            else a = 32'(MEM_BASE) + 32'(4 * $urandom_range(0, 511)) + 32'($urandom_range(0, 3));
            run_op(op, a, $urandom, 4'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
